axis_level_meter: RTL and testbench
===================================

Name: axis_level_meter

Overview:
- AXI-Stream pass-through stage that sits between the volume controller output and the I2S2 transmit input.
- Forwards every stereo sample unchanged through a 2-entry skid buffer, so it runs at full throughput with registered ready.
- Taps each accepted sample and keeps a per-channel peak magnitude that decays over time.
- Drives per-channel log-scale bar meters and a sticky clip flag for the board LEDs.

Parameters:
DATA_WIDTH, 24, sample width, signed two's complement.
METER_WIDTH, 6, number of bar segments per channel (must satisfy METER_WIDTH <= DATA_WIDTH-2).
DECAY_CYCLES, 4_000_000, clock cycles between peak decay steps (must be >= 2).

Ports:
clk  input  1  stream clock; all logic is in this domain.
reset  input  1  asynchronous, active-high reset.
s_axis_data  input  DATA_WIDTH  upstream sample.
s_axis_valid  input  1  upstream valid.
s_axis_ready  output  1  ready to upstream.
s_axis_last  input  1  channel tag: 0 = left, 1 = right.
m_axis_data  output  DATA_WIDTH  downstream sample.
m_axis_valid  output  1  downstream valid.
m_axis_ready  input  1  downstream ready.
m_axis_last  output  1  channel tag, forwarded unchanged.
meter_l  output  METER_WIDTH  left thermometer bar.
meter_r  output  METER_WIDTH  right thermometer bar.
clip  output  1  sticky full-scale indicator.
clip_clear  input  1  synchronous clear for clip.

Behaviour:
Reset values:
- m_axis_valid=0, m_axis_data=0, m_axis_last=0.
- Skid buffer empty, so s_axis_ready=1; no transfer is possible while reset is asserted.
- meter_l=0, meter_r=0, clip=0, peak_l=0, peak_r=0, decay counter=0.
- Reset asserted mid-operation discards any buffered beats and clears all state immediately.

Datapath / handshake:
- A beat is accepted when s_axis_valid&&s_axis_ready, and emitted when m_axis_valid&&m_axis_ready.
- Output register plus one skid register.
- s_axis_ready = !skid_valid, driven from a register.
- Accepted beat goes to the output register if it is empty or being drained this cycle; otherwise it goes to the skid register.
- When the output register drains and skid is full, skid moves to output.
- Latency is 1 cycle from accept to m_axis_valid with an empty buffer.
- Data and last are bit-exact and in order; no beat is dropped or duplicated.
- m_axis_data/last hold stable while m_axis_valid=1 and m_axis_ready=0.
- Sustained valid/ready=1 gives one beat per cycle.

Magnitude:
- mag = |data|, computed at DATA_WIDTH-1 bits.
- -2^(N-1) saturates to 2^(N-1)-1 (N = DATA_WIDTH).

Peak tracking (per channel; channel selected by s_axis_last at accept):
- Decay counter counts 0..DECAY_CYCLES-1 and wraps; the tick fires at the terminal count.
- On tick: peak <= peak >> 1 for both channels.
- On accept: peak_ch <= max(mag, base), where base = peak_ch>>1 if a tick fires in the same cycle, else peak_ch.
- The other channel is unaffected except by the tick.

Meters:
- Registered: meter bit k = (peak >= 2^(N-1-METER_WIDTH+k)), for k = 0..METER_WIDTH-1.
- With defaults, the thresholds are 2^17..2^22 (about -36 dBFS to -6 dBFS in 6 dB steps).
- Meter reflects peak one cycle after the peak register updates, i.e. 2 cycles after the accepting edge.
- Output is always a thermometer code (no holes).

Clip:
- Set on any accepted beat with mag == 2^(N-1)-1.
- Cleared by clip_clear=1.
- Set wins over clear in the same cycle.
- Unaffected by decay.

Test Plan:
- Throughput: 64 beats with alternating last, valid=1, m_axis_ready=1 → 64 beats out, in order, bit-exact; first m_axis_valid 1 cycle after first accept; s_axis_ready stays 1.
- Backpressure: m_axis_ready=0 for 5 cycles while upstream presents 0x000001, 0x000002, 0x000003 → 2 accepted, s_axis_ready=0 until drain; output 0x000001, 0x000002, 0x000003 exactly once each; data stable while stalled.
- Meter level: left sample 0x100000 (2^20) → meter_l=6'b001111 two cycles later; meter_r=0. Right sample 0xF00000 (-2^20) → meter_r=6'b001111.
- Decay (DECAY_CYCLES=16): left 0x400000 (2^22) → meter_l=6'b111111; after successive ticks → 6'b011111, 6'b001111, ..., 0 after 6 ticks. Sample 0x080000 accepted on the tick cycle as peak=0x100000 → peak=0x080000, meter_l=6'b000111.
- Clip/saturation: left 0x800000 → clip=1, meter_l=6'b111111; clip_clear pulse → clip=0; clip_clear and 0x7FFFFF in the same cycle → clip=1.
- Reset mid-stream: assert reset with 2 buffered beats and meters lit → m_axis_valid=0, meters=0, clip=0 immediately; after release, first new beat passes with 1-cycle latency.

Source files
------------

// File: rtl/axis_level_meter.sv
// AXI-Stream pass-through with a 2-entry skid buffer that taps accepted samples
// to drive decaying per-channel peak bar meters and a sticky clip flag.
module axis_level_meter #(
  parameter int DATA_WIDTH   = 24,
  parameter int METER_WIDTH  = 6,
  parameter int DECAY_CYCLES = 4_000_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [DATA_WIDTH-1:0]  s_axis_data,
  input  logic                   s_axis_valid,
  output logic                   s_axis_ready,
  input  logic                   s_axis_last,
  output logic [DATA_WIDTH-1:0]  m_axis_data,
  output logic                   m_axis_valid,
  input  logic                   m_axis_ready,
  output logic                   m_axis_last,
  output logic [METER_WIDTH-1:0] meter_l,
  output logic [METER_WIDTH-1:0] meter_r,
  output logic                   clip,
  input  logic                   clip_clear
);

  localparam int MAG_W = DATA_WIDTH - 1;
  localparam int CNT_W = $clog2(DECAY_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECAY_CYCLES - 1);
  localparam logic [MAG_W-1:0] MAG_FULL = '1;

  // Most negative input has no positive twin; it saturates to full scale.
  function automatic logic [MAG_W-1:0] sat_mag(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] neg;
    neg = -x;
    if (x[DATA_WIDTH-1] && (x[DATA_WIDTH-2:0] == '0)) return MAG_FULL;
    return x[DATA_WIDTH-1] ? neg[MAG_W-1:0] : x[MAG_W-1:0];
  endfunction

  function automatic logic [METER_WIDTH-1:0] therm(input logic [MAG_W-1:0] p);
    logic [METER_WIDTH-1:0] m;
    for (int k = 0; k < METER_WIDTH; k++) m[k] = |(p >> (MAG_W - METER_WIDTH + k));
    return m;
  endfunction

  logic                   out_vld_q, out_vld_d, out_last_q, out_last_d;
  logic [DATA_WIDTH-1:0]  out_data_q, out_data_d;
  logic                   skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;
  logic [DATA_WIDTH-1:0]  skid_data_q, skid_data_d;
  logic                   rdy_q, rdy_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [MAG_W-1:0]       peak_l_q, peak_l_d, peak_r_q, peak_r_d;
  logic [MAG_W-1:0]       mag, base_l, base_r;
  logic [METER_WIDTH-1:0] meter_l_q, meter_r_q;
  logic                   clip_q, clip_d;
  logic                   accept, drain, tick;

  always_comb begin
    accept      = s_axis_valid && rdy_q;
    drain       = out_vld_q && m_axis_ready;
    tick        = (cnt_q == CNT_LAST);
    mag         = sat_mag($signed(s_axis_data));
    out_vld_d   = out_vld_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    skid_vld_d  = skid_vld_q;
    skid_data_d = skid_data_q;
    skid_last_d = skid_last_q;
    if (drain) begin
      if (skid_vld_q) begin
        out_data_d = skid_data_q;
        out_last_d = skid_last_q;
        skid_vld_d = 1'b0;
      end else begin
        out_vld_d = 1'b0;
      end
    end
    // Ready is low whenever skid is full, so a drain plus accept never sees a full skid.
    if (accept) begin
      if (!out_vld_q || drain) begin
        out_vld_d  = 1'b1;
        out_data_d = s_axis_data;
        out_last_d = s_axis_last;
      end else begin
        skid_vld_d  = 1'b1;
        skid_data_d = s_axis_data;
        skid_last_d = s_axis_last;
      end
    end
    rdy_d = !skid_vld_d;

    cnt_d    = tick ? '0 : cnt_q + 1'b1;
    base_l   = tick ? (peak_l_q >> 1) : peak_l_q;
    base_r   = tick ? (peak_r_q >> 1) : peak_r_q;
    peak_l_d = base_l;
    peak_r_d = base_r;
    if (accept && !s_axis_last) peak_l_d = (mag > base_l) ? mag : base_l;
    if (accept && s_axis_last)  peak_r_d = (mag > base_r) ? mag : base_r;

    if (accept && (mag == MAG_FULL)) clip_d = 1'b1;
    else if (clip_clear)             clip_d = 1'b0;
    else                             clip_d = clip_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_vld_q   <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      skid_vld_q  <= 1'b0;
      skid_data_q <= '0;
      skid_last_q <= 1'b0;
      rdy_q       <= 1'b1;
      cnt_q       <= '0;
      peak_l_q    <= '0;
      peak_r_q    <= '0;
      meter_l_q   <= '0;
      meter_r_q   <= '0;
      clip_q      <= 1'b0;
    end else begin
      out_vld_q   <= out_vld_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      skid_vld_q  <= skid_vld_d;
      skid_data_q <= skid_data_d;
      skid_last_q <= skid_last_d;
      rdy_q       <= rdy_d;
      cnt_q       <= cnt_d;
      peak_l_q    <= peak_l_d;
      peak_r_q    <= peak_r_d;
      // Meters sample the peak registers, so they trail a peak update by one cycle.
      meter_l_q   <= therm(peak_l_q);
      meter_r_q   <= therm(peak_r_q);
      clip_q      <= clip_d;
    end
  end

  assign s_axis_ready = rdy_q;
  assign m_axis_valid = out_vld_q;
  assign m_axis_data  = out_data_q;
  assign m_axis_last  = out_last_q;
  assign meter_l      = meter_l_q;
  assign meter_r      = meter_r_q;
  assign clip         = clip_q;

endmodule

// File: tb/tb_axis_level_meter.sv
// Directed and randomized bench for axis_level_meter with a queue/integer reference model.
module tb_axis_level_meter;
  localparam int N  = 24;
  localparam int M  = 6;
  localparam int DC = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] s_axis_data, m_axis_data;
  logic         s_axis_valid, s_axis_ready, s_axis_last;
  logic         m_axis_valid, m_axis_ready, m_axis_last;
  logic [M-1:0] meter_l, meter_r;
  logic         clip, clip_clear;

  always #5 clk = ~clk;

  axis_level_meter #(.DATA_WIDTH(N), .METER_WIDTH(M), .DECAY_CYCLES(DC)) dut (
    .clk(clk), .reset(reset),
    .s_axis_data(s_axis_data), .s_axis_valid(s_axis_valid), .s_axis_ready(s_axis_ready),
    .s_axis_last(s_axis_last),
    .m_axis_data(m_axis_data), .m_axis_valid(m_axis_valid), .m_axis_ready(m_axis_ready),
    .m_axis_last(m_axis_last),
    .meter_l(meter_l), .meter_r(meter_r), .clip(clip), .clip_clear(clip_clear)
  );

  int checks = 0;
  int errors = 0;
  int nout   = 0;

  function automatic logic [M-1:0] therm(int p);
    logic [M-1:0] m;
    m = '0;
    for (int k = 0; k < M; k++) if (p >= (1 << (N - 1 - M + k))) m[k] = 1'b1;
    return m;
  endfunction

  function automatic int magn(logic [N-1:0] d);
    int v;
    v = int'($signed(d));
    if (v < 0) v = -v;
    if (v > (1 << (N - 1)) - 1) v = (1 << (N - 1)) - 1;
    return v;
  endfunction

  // Reference model: the buffer is a FIFO of at most two beats; peaks are plain integers.
  logic [N:0]   mq[$];
  int           m_cyc, m_pl, m_pr, m_mag;
  logic [M-1:0] m_ml, m_mr;
  logic         m_clip, m_acc, m_drn, m_tk;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      m_cyc = 0; m_pl = 0; m_pr = 0;
      m_ml = '0; m_mr = '0; m_clip = 1'b0;
    end else begin
      m_acc = s_axis_valid && (mq.size() < 2);
      m_drn = (mq.size() > 0) && m_axis_ready;
      m_tk  = (m_cyc % DC) == DC - 1;
      m_cyc++;
      m_ml = therm(m_pl);
      m_mr = therm(m_pr);
      if (m_drn) void'(mq.pop_front());
      if (m_acc) mq.push_back({s_axis_last, s_axis_data});
      if (m_tk) begin m_pl = m_pl / 2; m_pr = m_pr / 2; end
      m_mag = magn(s_axis_data);
      if (m_acc && s_axis_last  && m_mag > m_pr) m_pr = m_mag;
      if (m_acc && !s_axis_last && m_mag > m_pl) m_pl = m_mag;
      if (m_acc && m_mag == (1 << (N - 1)) - 1) m_clip = 1'b1;
      else if (clip_clear)                      m_clip = 1'b0;
    end
  end

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(string ph);
    chk({ph, ".ready"}, s_axis_ready, mq.size() < 2);
    chk({ph, ".valid"}, m_axis_valid, mq.size() > 0);
    if (mq.size() > 0) chk({ph, ".beat"}, {m_axis_last, m_axis_data}, mq[0]);
    chk({ph, ".meter_l"}, meter_l, m_ml);
    chk({ph, ".meter_r"}, meter_r, m_mr);
    chk({ph, ".clip"}, clip, m_clip);
  endtask

  // Transfers seen on the output are matched against beats in the order they were accepted.
  logic [N:0] sb[$];

  task automatic step(string ph);
    logic [N:0] e;
    if (m_axis_valid && m_axis_ready) begin
      if (sb.size() == 0) chk({ph, ".spurious"}, m_axis_valid, 1'b0);
      else begin
        e = sb.pop_front();
        chk({ph, ".xfer"}, {m_axis_last, m_axis_data}, e);
        nout++;
      end
    end
    if (s_axis_valid && mq.size() < 2) sb.push_back({s_axis_last, s_axis_data});
    @(posedge clk); #1;
    chk_all(ph);
  endtask

  task automatic sync(int ph, string tag);
    for (int i = 0; i < DC && (m_cyc % DC) != ph; i++) step(tag);
  endtask

  task automatic send(logic [N-1:0] d, logic l, string tag);
    logic a;
    a = 1'b0;
    s_axis_data = d; s_axis_last = l; s_axis_valid = 1'b1;
    for (int i = 0; i < 50 && !a; i++) begin
      a = (mq.size() < 2);
      step(tag);
    end
    s_axis_valid = 1'b0;
    if (!a) chk({tag, ".accept_timeout"}, s_axis_ready, 1'b1);
  endtask

  initial begin
    logic [M-1:0] exp_m;
    logic [N-1:0] first;
    reset = 1'b0; s_axis_data = '0; s_axis_valid = 1'b0; s_axis_last = 1'b0;
    m_axis_ready = 1'b1; clip_clear = 1'b0;
    #2 reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.m_valid", m_axis_valid, 1'b0);
    chk("rst.m_data", m_axis_data, 24'h0);
    chk("rst.m_last", m_axis_last, 1'b0);
    chk("rst.ready", s_axis_ready, 1'b1);
    chk("rst.meter_l", meter_l, 6'b0);
    chk("rst.meter_r", meter_r, 6'b0);
    chk("rst.clip", clip, 1'b0);
    reset = 1'b0;

    // Meter level, including the two-cycle meter latency
    sync(0, "lvl_sync");
    send(24'h100000, 1'b0, "lvl_l");
    chk("lvl.l_lat", meter_l, 6'b000000);
    step("lvl_l");
    chk("lvl.meter_l", meter_l, 6'b001111);
    chk("lvl.meter_r0", meter_r, 6'b000000);
    send(24'hF00000, 1'b1, "lvl_r");
    chk("lvl.r_lat", meter_r, 6'b000000);
    step("lvl_r");
    chk("lvl.meter_r", meter_r, 6'b001111);

    // Decay by successive ticks
    send(24'h400000, 1'b0, "dec");
    step("dec");
    chk("dec.full", meter_l, 6'b111111);
    exp_m = 6'b111111;
    for (int t = 1; t <= 6; t++) begin
      sync(0, "dec_wait");
      step("dec_tick");
      exp_m = exp_m >> 1;
      chk("dec.step", meter_l, exp_m);
    end

    // Accept coinciding with a tick
    sync(10, "tk_sync");
    send(24'h100000, 1'b0, "tk_set");
    sync(15, "tk_wait");
    chk("tk.pre", meter_l, 6'b001111);
    send(24'h080000, 1'b0, "tk_acc");
    step("tk");
    chk("tk.meter_l", meter_l, 6'b000111);

    // Clip and saturation
    send(24'h800000, 1'b0, "clip");
    chk("clip.set", clip, 1'b1);
    step("clip");
    chk("clip.meter_l", meter_l, 6'b111111);
    clip_clear = 1'b1;
    step("clip_clr");
    clip_clear = 1'b0;
    chk("clip.clear", clip, 1'b0);
    clip_clear = 1'b1;
    send(24'h7FFFFF, 1'b1, "clip_both");
    clip_clear = 1'b0;
    chk("clip.set_wins", clip, 1'b1);

    // Full-throughput random stream
    step("thr_idle"); step("thr_idle");
    nout = 0;
    s_axis_valid = 1'b1;
    first = '0;
    for (int i = 0; i < 64; i++) begin
      s_axis_data = N'($urandom_range(0, (1 << N) - 1));
      s_axis_last = i[0];
      if (i == 0) first = s_axis_data;
      step("thr");
      chk("thr.ready", s_axis_ready, 1'b1);
      if (i == 0) begin
        chk("thr.first_valid", m_axis_valid, 1'b1);
        chk("thr.first_data", m_axis_data, first);
      end
    end
    s_axis_valid = 1'b0;
    step("thr_tail"); step("thr_tail");
    chk("thr.count", nout, 64);
    chk("thr.sb_empty", sb.size(), 0);

    // Backpressure through the skid register
    nout = 0;
    m_axis_ready = 1'b0;
    s_axis_valid = 1'b1; s_axis_last = 1'b0; s_axis_data = 24'h000001;
    step("bp");
    s_axis_data = 24'h000002;
    step("bp");
    chk("bp.ready_low", s_axis_ready, 1'b0);
    s_axis_data = 24'h000003;
    repeat (3) begin
      step("bp_stall");
      chk("bp.stall_ready", s_axis_ready, 1'b0);
      chk("bp.stall_data", m_axis_data, 24'h000001);
    end
    m_axis_ready = 1'b1;
    send(24'h000003, 1'b0, "bp3");
    step("bp_drain"); step("bp_drain");
    chk("bp.count", nout, 3);

    // Reset with a full buffer and lit meters
    m_axis_ready = 1'b0;
    send(24'h800000, 1'b0, "mr");
    send(24'h400000, 1'b1, "mr");
    step("mr"); step("mr");
    chk("mr.clip_lit", clip, 1'b1);
    chk("mr.meter_lit", meter_l, 6'b111111);
    reset = 1'b1;
    #1;
    sb.delete();
    chk("mr.m_valid", m_axis_valid, 1'b0);
    chk("mr.ready", s_axis_ready, 1'b1);
    chk("mr.meter_l", meter_l, 6'b0);
    chk("mr.meter_r", meter_r, 6'b0);
    chk("mr.clip", clip, 1'b0);
    @(posedge clk); #1;
    reset = 1'b0;
    m_axis_ready = 1'b1;
    send(24'h123456, 1'b1, "post");
    chk("post.valid", m_axis_valid, 1'b1);
    chk("post.data", m_axis_data, 24'h123456);
    chk("post.last", m_axis_last, 1'b1);
    step("post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
